// File: rtl/blk_mem_gen_if.sv
// -----------------------------------------------------------------------------
// blk_mem_gen_if
// Port bundle for the single-port block memory.
//   ena   : port enable
//   wea   : write enable, only acts when ena is high
//   addra : word address
//   dina  : write data
//   douta : registered read data
// master : the side that issues accesses (multiplier top, testbench).
// slave  : the memory itself.
// -----------------------------------------------------------------------------
interface blk_mem_gen_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 4
);
  logic             ena;
  logic [0:0]       wea;
  logic [AW-1:0]    addra;
  logic [WIDTH-1:0] dina;
  logic [WIDTH-1:0] douta;

  modport master (output ena, wea, addra, dina, input douta);
  modport slave  (input ena, wea, addra, dina, output douta);
endinterface

// File: rtl/blk_mem_gen.sv
// -----------------------------------------------------------------------------
// blk_mem_gen
// Single-port synchronous block memory with preloadable contents, used as the
// operand store for the half-precision multiplier datapath.
//
// Ports:
//   clka : clock, everything happens on the rising edge
//   rsta : synchronous active-high reset, clears only the output registers
//   bus  : slave side of blk_mem_gen_if (ena, wea, addra, dina, douta)
//
// Behaviour:
//   - write-first: a write cycle returns dina on the read path
//   - ena low freezes the array and both output registers
//   - read latency is 1 cycle (OUT_REG = 0) or 2 cycles (OUT_REG = 1)
//   - douta is always driven from a register, never from an input
// -----------------------------------------------------------------------------
module blk_mem_gen #(
  parameter int                       WIDTH       = 16,
  parameter int                       DEPTH       = 16,
  parameter int                       AW          = 4,
  parameter logic [DEPTH*WIDTH-1:0]   INIT_VECTOR = '0,
  parameter bit                       OUT_REG     = 1'b0,
  parameter logic [WIDTH-1:0]         RST_VAL     = '0
) (
  input  logic          clka,
  input  logic          rsta,
  blk_mem_gen_if.slave  bus
);

  // Packed layout makes word i line up with INIT_VECTOR[i*WIDTH +: WIDTH],
  // so the power-on image is a direct assignment.
  logic [DEPTH-1:0][WIDTH-1:0] mem = INIT_VECTOR;

  // Output register starts at RST_VAL so douta is defined before the
  // first enabled read even if reset is never pulsed.
  logic [WIDTH-1:0] stage1 = RST_VAL;

  logic write_en;
  assign write_en = bus.ena & bus.wea[0];

  // NOTE: the array has no reset branch on purpose; rsta must never touch
  // contents, and a reset on the array would also prevent RAM inference.
  always_ff @(posedge clka) begin
    if (write_en) begin
      mem[bus.addra] <= bus.dina;
    end
  end

  // NOTE: non-blocking assignments keep the array write and the read
  // capture on the same edge order-independent; write-first is made
  // explicit by selecting dina rather than relying on update ordering.
  always_ff @(posedge clka) begin
    if (rsta) begin
      stage1 <= RST_VAL;
    end else if (bus.ena) begin
      stage1 <= bus.wea[0] ? bus.dina : mem[bus.addra];
    end
  end

  generate
    if (OUT_REG) begin : g_out_reg
      logic [WIDTH-1:0] stage2 = RST_VAL;

      always_ff @(posedge clka) begin
        if (rsta) begin
          stage2 <= RST_VAL;
        end else if (bus.ena) begin
          stage2 <= stage1;
        end
      end

      assign bus.douta = stage2;
    end else begin : g_no_out_reg
      assign bus.douta = stage1;
    end
  endgenerate

endmodule

// File: tb/tb_blk_mem_gen.sv
// -----------------------------------------------------------------------------
// tb_blk_mem_gen
// Drives identical traffic into two memories (single and double output
// register) preloaded with word i = 16'h3C00 + i. Expected read data comes
// from a word array plus a short history of returned words: the 1-cycle
// memory shows the newest entry, the 2-cycle memory the one before it.
// -----------------------------------------------------------------------------
module tb_blk_mem_gen;

  localparam int               W   = 16;
  localparam int               D   = 16;
  localparam int               AW  = 4;
  localparam logic [W-1:0]     RST = 16'h0000;

  function automatic logic [D*W-1:0] make_init();
    logic [D*W-1:0] v;
    for (int i = 0; i < D; i++) v[i*W +: W] = 16'h3C00 + W'(i);
    return v;
  endfunction

  localparam logic [D*W-1:0] INIT = make_init();

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  blk_mem_gen_if #(.WIDTH(W), .AW(AW)) bus0 ();
  blk_mem_gen_if #(.WIDTH(W), .AW(AW)) bus1 ();

  blk_mem_gen #(
    .WIDTH(W), .DEPTH(D), .AW(AW), .INIT_VECTOR(INIT), .OUT_REG(1'b0), .RST_VAL(RST)
  ) dut0 (
    .clka(clk), .rsta(rst), .bus(bus0.slave)
  );

  blk_mem_gen #(
    .WIDTH(W), .DEPTH(D), .AW(AW), .INIT_VECTOR(INIT), .OUT_REG(1'b1), .RST_VAL(RST)
  ) dut1 (
    .clka(clk), .rsta(rst), .bus(bus1.slave)
  );

  // Reference model.
  logic [W-1:0] ref_mem [D];
  logic [W-1:0] hist [$];   // last two words returned; hist[1] newest

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, let the edge happen, advance the model, compare.
  task automatic step(input logic r, input logic e, input logic we,
                      input logic [AW-1:0] a, input logic [W-1:0] d);
    rst        = r;
    bus0.ena   = e;  bus1.ena   = e;
    bus0.wea   = we; bus1.wea   = we;
    bus0.addra = a;  bus1.addra = a;
    bus0.dina  = d;  bus1.dina  = d;
    @(posedge clk);
    #1;
    if (r) begin
      hist.delete();
      hist.push_back(RST);
      hist.push_back(RST);
    end else if (e) begin
      hist.push_back(we ? d : ref_mem[a]);
      void'(hist.pop_front());
    end
    if (e && we) ref_mem[a] = d;
    check("model_lat1", bus0.douta, hist[1]);
    check("model_lat2", bus1.douta, hist[0]);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    step(1'b0, 1'b1, 1'b0, a, 'x);
  endtask

  initial begin
    logic [AW-1:0] ra;
    logic [W-1:0]  rd_data;

    for (int i = 0; i < D; i++) ref_mem[i] = 16'h3C00 + W'(i);
    hist.push_back(RST);
    hist.push_back(RST);

    rst = 1'b0;
    bus0.ena = 1'b0; bus1.ena = 1'b0;
    bus0.wea = 1'b0; bus1.wea = 1'b0;
    bus0.addra = '0; bus1.addra = '0;
    bus0.dina = '0;  bus1.dina = '0;

    // Power-on value before any enabled read.
    #1;
    check("poweron_lat1", bus0.douta, RST);
    check("poweron_lat2", bus1.douta, RST);

    step(1'b1, 1'b0, 1'b0, '0, '0);

    // Sequential readback with wrap 15 -> 0; latency 1 and latency 2.
    for (int i = 0; i <= D; i++) begin
      rd(AW'(i));
      check("seq_lat1", bus0.douta, 16'h3C00 + W'(i % D));
      if (i > 0) check("seq_lat2", bus1.douta, 16'h3C00 + W'((i - 1) % D));
    end

    // Write-first at address 5, neighbour untouched.
    step(1'b0, 1'b1, 1'b1, 4'd5, 16'hBEEF);
    check("wf_same_cycle", bus0.douta, 16'hBEEF);
    rd(4'd6);
    check("wf_neighbour", bus0.douta, 16'h3C06);
    rd(4'd5);
    check("wf_readback", bus0.douta, 16'hBEEF);

    // Enable hold with write attempts while disabled.
    rd(4'd3);
    check("hold_start", bus0.douta, 16'h3C03);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b1, AW'(i + 2), 16'h1234);
      check("hold_lat1", bus0.douta, 16'h3C03);
    end
    rd(4'd3);
    check("hold_array", bus0.douta, 16'h3C03);

    // Reset mid-stream, contents survive.
    rd(4'd7);
    step(1'b1, 1'b1, 1'b0, 4'd8, 'x);
    check("rst_lat1", bus0.douta, RST);
    check("rst_lat2", bus1.douta, RST);
    rd(4'd8);
    check("rst_release", bus0.douta, 16'h3C08);
    rd(4'd7);
    check("rst_array", bus0.douta, 16'h3C07);

    // Reset together with a write: output resets, array still written.
    step(1'b1, 1'b1, 1'b1, 4'd9, 16'hAAAA);
    check("rstw_lat1", bus0.douta, RST);
    rd(4'd9);
    check("rstw_readback", bus0.douta, 16'hAAAA);
    rd(4'd0);
    check("rstw_lat2", bus1.douta, 16'hAAAA);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      ra      = AW'($urandom_range(0, D - 1));
      rd_data = W'($urandom);
      step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 3) == 0), ra, rd_data);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
